// File: rtl/controlador_mux_ula_if.sv
// Bundle between the requesters/ALU mux and the round-robin mux controller.
// master = requester/mux side, slave = controller side.
interface controlador_mux_ula_if;
    logic [3:0]  req;
    logic [11:0] op;
    logic [2:0]  sel;
    logic [3:0]  mux_y;
    logic [3:0]  resultado;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;

    modport master (
        output req, op, mux_y,
        input  sel, resultado, gnt, done, busy
    );

    modport slave (
        input  req, op, mux_y,
        output sel, resultado, gnt, done, busy
    );
endinterface

// File: rtl/controlador_mux_ula.sv
// Round-robin owner of a shared 4-bit 8:1 ALU result mux.
// Grants one requester, holds its op as select, captures Y after settling.
module controlador_mux_ula #(
    parameter int SETTLE_CYCLES = 1
) (
    input logic                  clk,
    input logic                  rst,
    controlador_mux_ula_if.slave bus
);
    typedef enum logic [1:0] {
        OCIOSO,
        SELECIONA,
        CONCLUI
    } estado_t;

    localparam logic [3:0] CARGA = 4'(SETTLE_CYCLES - 1);

    estado_t    estado, estado_n;
    logic [3:0] cont, cont_n;
    logic [1:0] ultimo, ultimo_n;
    logic [2:0] sel, sel_n;
    logic [3:0] resultado, resultado_n;
    logic [3:0] gnt, gnt_n;
    logic [3:0] done, done_n;
    logic [1:0] vencedor;
    logic [1:0] idx;
    logic       achou;
    logic [2:0] op_v;

    // Winner: first requester after the last one served, wrapping
    always_comb begin
        vencedor = ultimo;
        achou    = 1'b0;
        idx      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = ultimo + 2'(k);
            if (!achou && bus.req[idx]) begin
                achou    = 1'b1;
                vencedor = idx;
            end
        end
    end

    // Op code of the winning requester
    always_comb begin
        op_v = 3'd0;
        unique case (vencedor)
            2'd0:    op_v = bus.op[2:0];
            2'd1:    op_v = bus.op[5:3];
            2'd2:    op_v = bus.op[8:6];
            2'd3:    op_v = bus.op[11:9];
            default: op_v = 3'd0;
        endcase
    end

    // Next state and next register values
    always_comb begin
        estado_n    = estado;
        cont_n      = cont;
        ultimo_n    = ultimo;
        sel_n       = sel;
        resultado_n = resultado;
        gnt_n       = gnt;
        done_n      = done;
        unique case (estado)
            OCIOSO: begin
                if (achou) begin
                    gnt_n    = 4'b0001 << vencedor;
                    sel_n    = op_v;
                    cont_n   = CARGA;
                    ultimo_n = vencedor;
                    estado_n = SELECIONA;
                end
            end
            SELECIONA: begin
                if (cont != 4'd0) begin
                    cont_n = cont - 4'd1;
                end else begin
                    resultado_n = bus.mux_y;
                    done_n      = gnt;
                    gnt_n       = 4'b0000;
                    estado_n    = CONCLUI;
                end
            end
            CONCLUI: begin
                done_n   = 4'b0000;
                estado_n = OCIOSO;
            end
            default: begin
                gnt_n    = 4'b0000;
                done_n   = 4'b0000;
                estado_n = OCIOSO;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado    <= OCIOSO;
            cont      <= 4'd0;
            ultimo    <= 2'd3;
            sel       <= 3'd0;
            resultado <= 4'd0;
            gnt       <= 4'd0;
            done      <= 4'd0;
        end else begin
            estado    <= estado_n;
            cont      <= cont_n;
            ultimo    <= ultimo_n;
            sel       <= sel_n;
            resultado <= resultado_n;
            gnt       <= gnt_n;
            done      <= done_n;
        end
    end

    assign bus.sel       = sel;
    assign bus.resultado = resultado;
    assign bus.gnt       = gnt;
    assign bus.done      = done;
    assign bus.busy      = (estado != OCIOSO);
endmodule

// File: tb/tb_controlador_mux_ula.sv
// Directed bench for controlador_mux_ula: a settle-1 and a settle-3 instance.
// Outputs packed as {gnt, sel, resultado, done, busy} for comparison.
module tb_controlador_mux_ula;
    logic clk;
    logic rst;
    int   erros;
    int   checks;

    controlador_mux_ula_if bus1 ();
    controlador_mux_ula_if bus3 ();

    controlador_mux_ula #(.SETTLE_CYCLES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    controlador_mux_ula #(.SETTLE_CYCLES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [11:0] op;
        logic [3:0]  my;
        logic [3:0]  gnt;
        logic [2:0]  sel;
        logic [3:0]  res;
        logic [3:0]  done;
        logic        busy;
    } vetor_t;

    localparam int NV = 25;
    vetor_t tab [NV];

    function automatic logic [15:0] pac(logic [3:0] g, logic [2:0] s,
                                        logic [3:0] r, logic [3:0] d,
                                        logic b);
        return {g, s, r, d, b};
    endfunction

    function automatic logic [15:0] saida1();
        return pac(bus1.gnt, bus1.sel, bus1.resultado, bus1.done, bus1.busy);
    endfunction

    function automatic logic [15:0] saida3();
        return pac(bus3.gnt, bus3.sel, bus3.resultado, bus3.done, bus3.busy);
    endfunction

    task automatic verifica(string nome, int n, logic [15:0] obtido,
                            logic [15:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            erros++;
            $display("FAIL %s[%0d]: got gnt=%b sel=%0d res=%h done=%b busy=%b, expected gnt=%b sel=%0d res=%h done=%b busy=%b",
                     nome, n,
                     obtido[15:12], obtido[11:9], obtido[8:5], obtido[4:1], obtido[0],
                     esperado[15:12], esperado[11:9], esperado[8:5], esperado[4:1], esperado[0]);
        end
    endtask

    task automatic passo();
        @(posedge clk);
        #1;
    endtask

    // gnt/done exclusivity and one-hotness on every cycle
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((bus1.gnt & bus1.done) != 4'd0 || $countones(bus1.gnt) > 1 ||
                $countones(bus1.done) > 1 || (bus3.gnt & bus3.done) != 4'd0 ||
                $countones(bus3.gnt) > 1 || $countones(bus3.done) > 1) begin
                erros++;
                $display("FAIL onehot: gnt1=%b done1=%b gnt3=%b done3=%b",
                         bus1.gnt, bus1.done, bus3.gnt, bus3.done);
            end
        end
    end

    initial begin
        erros  = 0;
        checks = 0;
        //            rst req      op      my    gnt      sel   res   done     busy
        tab[0]  = '{1'b0, 4'b0001, 12'h005, 4'h0, 4'b0001, 3'd5, 4'h0, 4'b0000, 1'b1};
        tab[1]  = '{1'b0, 4'b0001, 12'h005, 4'hA, 4'b0000, 3'd5, 4'hA, 4'b0001, 1'b1};
        tab[2]  = '{1'b0, 4'b0000, 12'h005, 4'h0, 4'b0000, 3'd5, 4'hA, 4'b0000, 1'b0};
        tab[3]  = '{1'b1, 4'b0000, 12'h000, 4'h0, 4'b0000, 3'd0, 4'h0, 4'b0000, 1'b0};
        tab[4]  = '{1'b0, 4'b1111, 12'h68C, 4'h0, 4'b0001, 3'd4, 4'h0, 4'b0000, 1'b1};
        tab[5]  = '{1'b0, 4'b1111, 12'h68C, 4'h1, 4'b0000, 3'd4, 4'h1, 4'b0001, 1'b1};
        tab[6]  = '{1'b0, 4'b1110, 12'h68C, 4'h0, 4'b0000, 3'd4, 4'h1, 4'b0000, 1'b0};
        tab[7]  = '{1'b0, 4'b1110, 12'h68C, 4'h0, 4'b0010, 3'd1, 4'h1, 4'b0000, 1'b1};
        tab[8]  = '{1'b0, 4'b1110, 12'h68C, 4'h2, 4'b0000, 3'd1, 4'h2, 4'b0010, 1'b1};
        tab[9]  = '{1'b0, 4'b1100, 12'h68C, 4'h0, 4'b0000, 3'd1, 4'h2, 4'b0000, 1'b0};
        tab[10] = '{1'b0, 4'b1100, 12'h68C, 4'h0, 4'b0100, 3'd2, 4'h2, 4'b0000, 1'b1};
        tab[11] = '{1'b0, 4'b1100, 12'h68C, 4'h3, 4'b0000, 3'd2, 4'h3, 4'b0100, 1'b1};
        tab[12] = '{1'b0, 4'b1000, 12'h68C, 4'h0, 4'b0000, 3'd2, 4'h3, 4'b0000, 1'b0};
        tab[13] = '{1'b0, 4'b1000, 12'h68C, 4'h0, 4'b1000, 3'd3, 4'h3, 4'b0000, 1'b1};
        tab[14] = '{1'b0, 4'b1000, 12'h68C, 4'h4, 4'b0000, 3'd3, 4'h4, 4'b1000, 1'b1};
        tab[15] = '{1'b0, 4'b0000, 12'h68C, 4'h0, 4'b0000, 3'd3, 4'h4, 4'b0000, 1'b0};
        tab[16] = '{1'b0, 4'b0100, 12'h180, 4'h0, 4'b0100, 3'd6, 4'h4, 4'b0000, 1'b1};
        tab[17] = '{1'b0, 4'b0100, 12'h180, 4'h5, 4'b0000, 3'd6, 4'h5, 4'b0100, 1'b1};
        tab[18] = '{1'b0, 4'b1001, 12'hE01, 4'h0, 4'b0000, 3'd6, 4'h5, 4'b0000, 1'b0};
        tab[19] = '{1'b0, 4'b1001, 12'hE01, 4'h0, 4'b1000, 3'd7, 4'h5, 4'b0000, 1'b1};
        tab[20] = '{1'b0, 4'b1001, 12'hE01, 4'h6, 4'b0000, 3'd7, 4'h6, 4'b1000, 1'b1};
        tab[21] = '{1'b0, 4'b0001, 12'hE01, 4'h0, 4'b0000, 3'd7, 4'h6, 4'b0000, 1'b0};
        tab[22] = '{1'b0, 4'b0001, 12'hE01, 4'h0, 4'b0001, 3'd1, 4'h6, 4'b0000, 1'b1};
        tab[23] = '{1'b0, 4'b0001, 12'hE01, 4'h7, 4'b0000, 3'd1, 4'h7, 4'b0001, 1'b1};
        tab[24] = '{1'b0, 4'b0000, 12'hE01, 4'h0, 4'b0000, 3'd1, 4'h7, 4'b0000, 1'b0};

        rst        = 1'b1;
        bus1.req   = 4'd0;
        bus1.op    = 12'd0;
        bus1.mux_y = 4'd0;
        bus3.req   = 4'd0;
        bus3.op    = 12'd0;
        bus3.mux_y = 4'd0;
        repeat (2) passo();
        verifica("reset1", 0, saida1(), 16'd0);
        verifica("reset3", 0, saida3(), 16'd0);
        rst = 1'b0;

        // Table: single op, 1111 rotation, 2-then-1001 priority
        for (int i = 0; i < NV; i++) begin
            rst        = tab[i].rst;
            bus1.req   = tab[i].req;
            bus1.op    = tab[i].op;
            bus1.mux_y = tab[i].my;
            passo();
            verifica("tab", i, saida1(),
                     pac(tab[i].gnt, tab[i].sel, tab[i].res, tab[i].done, tab[i].busy));
        end
        bus1.req = 4'd0;

        // Settle 3: op1=7, mux_y wanders, C at capture edge
        bus3.req   = 4'b0010;
        bus3.op    = 12'h03D;
        bus3.mux_y = 4'h1;
        passo();
        verifica("s3_e0", 0, saida3(), pac(4'b0010, 3'd7, 4'h0, 4'b0000, 1'b1));
        bus3.req   = 4'b0000;
        bus3.op    = 12'h000;
        bus3.mux_y = 4'h2;
        passo();
        verifica("s3_e1", 1, saida3(), pac(4'b0010, 3'd7, 4'h0, 4'b0000, 1'b1));
        bus3.mux_y = 4'h9;
        passo();
        verifica("s3_e2", 2, saida3(), pac(4'b0010, 3'd7, 4'h0, 4'b0000, 1'b1));
        bus3.mux_y = 4'hC;
        passo();
        verifica("s3_e3", 3, saida3(), pac(4'b0000, 3'd7, 4'hC, 4'b0010, 1'b1));
        bus3.mux_y = 4'h0;
        passo();
        verifica("s3_e4", 4, saida3(), pac(4'b0000, 3'd7, 4'hC, 4'b0000, 1'b0));

        // Reset in the middle of SELECIONA
        bus3.req = 4'b0001;
        bus3.op  = 12'h003;
        passo();
        verifica("rst_g", 0, saida3(), pac(4'b0001, 3'd3, 4'hC, 4'b0000, 1'b1));
        bus3.req = 4'b0000;
        passo();
        verifica("rst_w", 1, saida3(), pac(4'b0001, 3'd3, 4'hC, 4'b0000, 1'b1));
        #3;
        rst = 1'b1;
        #1;
        verifica("rst_async3", 0, saida3(), 16'd0);
        verifica("rst_async1", 0, saida1(), 16'd0);
        passo();
        verifica("rst_hold", 0, saida3(), 16'd0);
        passo();
        verifica("rst_hold", 1, saida3(), 16'd0);
        rst        = 1'b0;
        bus3.req   = 4'b0011;
        bus3.op    = 12'h015;
        bus3.mux_y = 4'h6;
        passo();
        verifica("rst_after", 0, saida3(), pac(4'b0001, 3'd5, 4'h0, 4'b0000, 1'b1));
        bus3.req = 4'b0010;
        repeat (2) passo();
        passo();
        verifica("rst_after", 1, saida3(), pac(4'b0000, 3'd5, 4'h6, 4'b0001, 1'b1));
        bus3.req = 4'b0000;
        passo();
        verifica("rst_after", 2, saida3(), pac(4'b0000, 3'd5, 4'h6, 4'b0000, 1'b0));

        // Requester 0 stays up after done while 2 waits; op0 changed mid-service
        bus1.req   = 4'b0101;
        bus1.op    = 12'h102;
        bus1.mux_y = 4'h0;
        passo();
        verifica("keep", 0, saida1(), pac(4'b0001, 3'd2, 4'h0, 4'b0000, 1'b1));
        bus1.op    = 12'h106;
        bus1.mux_y = 4'h8;
        passo();
        verifica("keep", 1, saida1(), pac(4'b0000, 3'd2, 4'h8, 4'b0001, 1'b1));
        passo();
        verifica("keep", 2, saida1(), pac(4'b0000, 3'd2, 4'h8, 4'b0000, 1'b0));
        passo();
        verifica("keep", 3, saida1(), pac(4'b0100, 3'd4, 4'h8, 4'b0000, 1'b1));
        bus1.mux_y = 4'h9;
        passo();
        verifica("keep", 4, saida1(), pac(4'b0000, 3'd4, 4'h9, 4'b0100, 1'b1));
        bus1.req = 4'b0001;
        passo();
        verifica("keep", 5, saida1(), pac(4'b0000, 3'd4, 4'h9, 4'b0000, 1'b0));
        passo();
        verifica("keep", 6, saida1(), pac(4'b0001, 3'd6, 4'h9, 4'b0000, 1'b1));
        bus1.req   = 4'b0000;
        bus1.mux_y = 4'h3;
        passo();
        verifica("keep", 7, saida1(), pac(4'b0000, 3'd6, 4'h3, 4'b0001, 1'b1));
        passo();
        verifica("keep", 8, saida1(), pac(4'b0000, 3'd6, 4'h3, 4'b0000, 1'b0));

        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end
endmodule
